// File: rtl/arr_pkg.sv
// Shared definitions for the row-skew feeder: FSM encoding and the default lane-slice width.
package arr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int LANE_W = 8;

endpackage

// File: rtl/row_skew_line.sv
// Per-lane delay line: DEPTH-stage shift register carrying a data word and its valid bit.
module row_skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign out_vld = in_vld;
    assign out_dat = in_dat;
  end else begin : g_shift
    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rstn) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= in_vld;
        dat_q[0] <= in_dat;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/row_skew_feeder.sv
// Reads ROWS-word vectors from the input memory and issues each one into diagonally
// skewed lanes, so lane r sees the vector r cycles after lane 0.
module row_skew_feeder
  import arr_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int WORD_LEN = LANE_W,
  parameter int ADDR_W   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [7:0]               num_vecs,
  output logic                     mem_cen,
  output logic [ADDR_W-1:0]        mem_a,
  input  logic [WORD_LEN-1:0]      mem_q,
  output logic [ROWS*WORD_LEN-1:0] row_dat,
  output logic [ROWS-1:0]          row_vld,
  output logic                     busy,
  output logic                     done,
  output state_t                   dbg_state
);

  localparam int KW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = (ROWS > 1) ? ROWS - 1 : 1;
  localparam logic [KW-1:0] LAST_K = KW'(ROWS - 1);

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [7:0]        v_q, v_d;
  logic [7:0]        nv_q, nv_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              mem_cen_q, mem_cen_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WORD_LEN-1:0]      stage_q [SW];
  logic [ROWS-1:0]          row_vld_q, lane_vld;
  logic [ROWS*WORD_LEN-1:0] row_dat_q, lane_dat;
  logic                     issue;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      v_q     <= '0;
      nv_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      v_q     <= v_d;
      nv_q    <= nv_d;
      base_q  <= base_d;
    end
  end

  // Next state; k doubles as the word index in FETCH and the cycle count in DRAIN
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    v_d     = v_q;
    nv_d    = nv_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          nv_d    = num_vecs;
          v_d     = '0;
          k_d     = '0;
          state_d = (num_vecs == 8'd0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (k_q == LAST_K) begin
          k_d     = '0;
          state_d = ST_ISSUE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        k_d = '0;
        if (v_q == nv_q - 8'd1) begin
          state_d = ST_DRAIN;
        end else begin
          v_d     = v_q + 8'd1;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (k_q == LAST_K) begin
          k_d     = '0;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state
  always_comb begin
    mem_cen_d = 1'b1;
    mem_a_d   = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    if (state_d == ST_FETCH) begin
      mem_cen_d = 1'b0;
      mem_a_d   = base_d + (ADDR_W'(v_d) * ADDR_W'(ROWS)) + ADDR_W'(k_d);
    end
    busy_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_cen_q <= 1'b1;
      mem_a_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      row_vld_q <= '0;
      row_dat_q <= '0;
    end else begin
      mem_cen_q <= mem_cen_d;
      mem_a_q   <= mem_a_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      row_vld_q <= lane_vld;
      row_dat_q <= lane_dat;
    end
  end

  // Word k arrives while the read for k+1 is in flight; the last word goes straight to its lane
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < SW; s++) stage_q[s] <= '0;
    end else begin
      for (int s = 0; s < SW; s++) begin
        if (state_q == ST_FETCH && int'(k_q) == s + 1) stage_q[s] <= mem_q;
      end
    end
  end

  assign issue = (state_q == ST_ISSUE);

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WORD_LEN-1:0] in_dat;
    logic [WORD_LEN-1:0] out_dat;
    logic                out_vld;

    if (r == ROWS - 1) begin : g_last
      assign in_dat = issue ? mem_q : '0;
    end else begin : g_staged
      assign in_dat = issue ? stage_q[r] : '0;
    end

    row_skew_line #(
      .DEPTH(r),
      .W    (WORD_LEN)
    ) u_line (
      .clk    (clk),
      .rstn   (rstn),
      .in_vld (issue),
      .in_dat (in_dat),
      .out_vld(out_vld),
      .out_dat(out_dat)
    );

    assign lane_vld[r]                      = out_vld;
    assign lane_dat[r*WORD_LEN +: WORD_LEN] = out_vld ? out_dat : '0;
  end

  assign mem_cen   = mem_cen_q;
  assign mem_a     = mem_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign row_vld   = row_vld_q;
  assign row_dat   = row_dat_q;
  assign dbg_state = state_q;

endmodule
